// File: rtl/shift_rx_pkg.sv
// Shared types and constants for the serial-to-parallel shift receiver.
// SHIFT_RX_PARITY_EN adds one trailing even-parity bit to every frame.
package shift_rx_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Serial bits per frame, including the parity bit when it is enabled.
    function automatic int frame_len(input int width);
`ifdef SHIFT_RX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/shift_rx_if.sv
// Serial-in / word-out bundle of the shift receiver.
// The master drives bits and out_ready; the slave is the receiver.
interface shift_rx_if
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_bit;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;
    logic             parity_err;

    modport master (
        output in_valid, in_bit, out_ready,
        input  out_data, out_valid, overrun, parity_err
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output out_data, out_valid, overrun, parity_err
    );
endinterface

// File: rtl/rx_bit_counter.sv
// Bit-position counter for one frame. Clear and increment together
// restart the count at 1, so it never runs past the frame length.
module rx_bit_counter #(
    parameter int              CNT_W = 4,
    parameter logic [CNT_W-1:0] LAST = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_clr)
            r_count <= i_inc ? CNT_W'(1) : '0;
        else if (i_inc)
            r_count <= r_count + CNT_W'(1);
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST);
endmodule

// File: rtl/shift_receiver.sv
// MSB-first serial receiver with a one-word output holding register.
// Define SHIFT_RX_PARITY_EN to expect a trailing even-parity bit per frame.
module shift_receiver
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    shift_rx_if.slave  bus
);
    localparam int               FRAME = frame_len(WIDTH);
    localparam int               CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME - 1);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic [CNT_W-1:0] w_count;
    logic             w_last;
    logic             w_cnt_clr, w_cnt_inc;
    logic             w_first, w_shift, w_load, w_take, w_drop;

    rx_bit_counter #(.CNT_W(CNT_W), .LAST(LAST)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (w_count),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_first     = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_take      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_first     = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.in_valid) begin
                    if (w_last) begin
                        w_load      = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_shift   = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_take = 1'b1;
                    // A bit arriving in the handshake cycle opens the next frame.
                    if (bus.in_valid) begin
                        w_first     = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_cnt_inc   = 1'b1;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_drop = bus.in_valid;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_take)
                r_valid <= 1'b0;
            if (w_first)
                r_shift <= {{(WIDTH-1){1'b0}}, bus.in_bit};
            else if (w_shift)
                r_shift <= {r_shift[WIDTH-2:0], bus.in_bit};
            if (w_load) begin
                r_valid <= 1'b1;
`ifdef SHIFT_RX_PARITY_EN
                r_data  <= r_shift;
`else
                r_data  <= {r_shift[WIDTH-2:0], bus.in_bit};
`endif
            end
        end
    end

`ifdef SHIFT_RX_PARITY_EN
    logic r_perr;

    // The completing bit is the parity bit; it never enters the data word.
    always_ff @(posedge clk) begin
        if (reset)       r_perr <= 1'b0;
        else if (w_load) r_perr <= ^{r_shift, bus.in_bit};
    end

    assign bus.parity_err = r_perr;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_shift_receiver.sv
// Directed and randomized bench for shift_receiver against a bit-queue
// reference model; honours SHIFT_RX_PARITY_EN like the design.
module tb_shift_receiver;
    localparam int W = 8;
`ifdef SHIFT_RX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   ov_cnt = 0;
    logic [W-1:0] got_q[$];

    // reference model: accumulated bits, presented word, flags
    logic [63:0]  m_acc = '0;
    int           m_nb = 0;
    bit           m_pres = 1'b0;
    logic [W-1:0] m_word = '0;
    bit           m_ovr = 1'b0;
    bit           m_perr = 1'b0;

    shift_rx_if #(.WIDTH(W)) bus ();

    shift_receiver #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit v, input bit b, input bit r, input bit rst);
        if (rst) begin
            m_acc = '0; m_nb = 0; m_pres = 0; m_word = '0; m_ovr = 0; m_perr = 0;
            return;
        end
        m_ovr = 0;
        if (m_pres) begin
            if (r) begin
                m_pres = 0;
                if (v) begin m_acc = 64'(b); m_nb = 1; end
                else   begin m_acc = '0;     m_nb = 0; end
            end else if (v) begin
                m_ovr = 1;
            end
        end else if (v) begin
            m_acc = (m_acc << 1) | 64'(b);
            m_nb++;
            if (m_nb == FRAME) begin
                m_pres = 1;
                m_nb = 0;
`ifdef SHIFT_RX_PARITY_EN
                m_word = m_acc[W:1];
                m_perr = ^m_acc[W:0];
`else
                m_word = m_acc[W-1:0];
`endif
            end
        end
    endtask

    task automatic step(input bit v, input bit b, input bit r, input bit rst);
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.out_ready = r;
        reset         = rst;
        if (bus.out_valid === 1'b1 && r && !rst) got_q.push_back(bus.out_data);
        @(posedge clk);
        model(v, b, r, rst);
        #1;
        if (bus.overrun === 1'b1) ov_cnt++;
        chk("out_valid",  32'(bus.out_valid),  32'(m_pres));
        chk("out_data",   32'(bus.out_data),   32'(m_word));
        chk("overrun",    32'(bus.overrun),    32'(m_ovr));
        chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit p, input bit r, input bit gap);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, (i < W) ? w[W-1-i] : p, r, 1'b0);
            if (gap && i == 3) repeat (3) step(1'b0, 1'b0, r, 1'b0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);

        // A5 with consumer always ready: one presentation cycle
        send_frame(8'hA5, ^8'hA5, 1'b1, 1'b0);
        chk("a5_valid", 32'(bus.out_valid), 32'd1);
        chk("a5_data",  32'(bus.out_data),  32'hA5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_single", 32'(bus.out_valid), 32'd0);

        // gapped A5, held for 5 cycles, then 2 dropped bits
        send_frame(8'hA5, ^8'hA5, 1'b0, 1'b1);
        chk("hold_data0", 32'(bus.out_data), 32'hA5);
        repeat (4) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("hold_data", 32'(bus.out_data), 32'hA5);
            chk("hold_vld",  32'(bus.out_valid), 32'd1);
        end
        ov_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulses", 32'(ov_cnt), 32'd2);
        chk("ovr_data",   32'(bus.out_data), 32'hA5);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // back-to-back 3C / C3, next frame starts in handshake cycle
        got_q.delete();
        ov_cnt = 0;
        send_frame(8'h3C, ^8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, ^8'hC3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("b2b_w0", 32'(got_q[0]), 32'h3C);
            chk("b2b_w1", 32'(got_q[1]), 32'hC3);
        end
        chk("b2b_ovr", 32'(ov_cnt), 32'd0);

        // reset mid-frame discards the partial word
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_mid_vld", 32'(bus.out_valid), 32'd0);
        send_frame(8'hFF, ^8'hFF, 1'b0, 1'b0);
        chk("ff_valid", 32'(bus.out_valid), 32'd1);
        chk("ff_data",  32'(bus.out_data),  32'hFF);
        step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SHIFT_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        chk("par_ok",  32'(bus.parity_err), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h07, 1'b0, 1'b0, 1'b0);
        chk("par_bad", 32'(bus.parity_err), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
